// File: rtl/fifo_adapt_pkg.sv
// Shared definitions for the FIFO width-adaptation blocks: state encoding,
// reset polarity and a constant-friendly ceil(log2) helper.
package fifo_adapt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Level of RST that holds the adapters in reset.
  localparam logic RST_ACTIVE = 1'b1;

  // Ceil(log2(value)); usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_unpack_reader.sv
// Pops one wide word from an upstream FIFO and emits it as RATIO narrow beats
// into a downstream FIFO, with no bubble between consecutive words.
module fifo_unpack_reader
  import fifo_adapt_pkg::*;
#(
  parameter int in_width  = 32,
  parameter int out_width = 8,
  parameter bit lsb_first = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic [in_width-1:0]  SRC_D_OUT,
  input  logic                 SRC_EMPTY_N,
  output logic                 SRC_DEQ,
  output logic [out_width-1:0] DST_D_IN,
  output logic                 DST_ENQ,
  input  logic                 DST_FULL_N,
  output logic                 DST_LAST,
  output logic                 BUSY
);

  localparam int RATIO    = in_width / out_width;
  localparam int CW       = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
  localparam bit RATIO_OK = (in_width % out_width == 0) && (RATIO >= 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  state_t                             st, st_nxt;
  logic [CW-1:0]                      cnt, cnt_nxt;
  logic [in_width-1:0]                hold_reg, hold_nxt;
  logic [RATIO-1:0][out_width-1:0]    hold_slices;
  logic [CW-1:0]                      slice_sel;
  logic                               rst_on;
  logic                               sending;
  logic                               last_beat;

  assign rst_on      = (RST == RST_ACTIVE);
  assign hold_slices = hold_reg;

  // Beat data comes straight from the held word, never from SRC_D_OUT.
  assign slice_sel = lsb_first ? cnt : (CNT_LAST - cnt);
  assign DST_D_IN  = hold_slices[slice_sel];

  // State register: held word, beat counter and FSM state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      // NOTE: the word register is a plain register, not a memory, so it is
      // cleared here to keep DST_D_IN at zero while reset is held.
      hold_reg <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      st       <= st_nxt;
      cnt      <= cnt_nxt;
      hold_reg <= hold_nxt;
    end
  end

  // Handshake outputs and next-state decode; CLR overrides everything.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the branches below can infer a latch.
    st_nxt    = st;
    cnt_nxt   = cnt;
    hold_nxt  = hold_reg;

    sending   = (st == ST_SEND);
    last_beat = sending && (cnt == CNT_LAST);
    BUSY      = sending && !rst_on;
    DST_ENQ   = sending && DST_FULL_N && !CLR && !rst_on;
    DST_LAST  = DST_ENQ && last_beat;
    SRC_DEQ   = SRC_EMPTY_N && !CLR && !rst_on &&
                (!sending || (last_beat && DST_FULL_N));

    if (CLR) begin
      st_nxt  = ST_IDLE;
      cnt_nxt = '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (SRC_DEQ) begin
            hold_nxt = SRC_D_OUT;
            cnt_nxt  = '0;
            st_nxt   = ST_SEND;
          end
        end
        ST_SEND: begin
          if (DST_ENQ) begin
            if (!last_beat) begin
              cnt_nxt = cnt + 1'b1;
            end else if (SRC_DEQ) begin
              hold_nxt = SRC_D_OUT;
              cnt_nxt  = '0;
            end else begin
              cnt_nxt = '0;
              st_nxt  = ST_IDLE;
            end
          end
        end
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  // Simulation-only protocol and configuration checks.
  always_ff @(posedge CLK) begin
    if (!rst_on) begin
      a_ratio: assert (RATIO_OK)
        else $error("fifo_unpack_reader: in_width must be a multiple >= 2 of out_width");
      a_deq_empty: assert (!(SRC_DEQ && !SRC_EMPTY_N))
        else $error("fifo_unpack_reader: SRC_DEQ while upstream empty");
      a_enq_full: assert (!(DST_ENQ && !DST_FULL_N))
        else $error("fifo_unpack_reader: DST_ENQ while downstream full");
    end
  end

endmodule

// File: tb/tb_fifo_unpack_reader.sv
// Bench for fifo_unpack_reader: an LSB-first and an MSB-first instance share
// the stimulus and are compared every cycle against a beat-queue model.
module tb_fifo_unpack_reader;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int RATIO = IN_W / OUT_W;
  localparam logic [23:0] DATA_MASK_OFF = 24'hF00F00;

  logic CLK = 1'b0;
  logic RST, CLR, SRC_EMPTY_N, DST_FULL_N;
  logic [IN_W-1:0] SRC_D_OUT;
  logic SRC_DEQ, DST_ENQ, DST_LAST, BUSY;
  logic [OUT_W-1:0] DST_D_IN;
  logic m_src_deq, m_dst_enq, m_dst_last, m_busy;
  logic [OUT_W-1:0] m_dst_d_in;

  int checks = 0;
  int errors = 0;

  // Model: beats still owed downstream for the word in flight, and the
  // words waiting in the upstream FIFO.
  typedef struct {
    logic [OUT_W-1:0] lsb;
    logic [OUT_W-1:0] msb;
  } beat_t;
  beat_t          bq[$];
  logic [IN_W-1:0] src_q[$];

  fifo_unpack_reader #(.in_width(IN_W), .out_width(OUT_W), .lsb_first(1'b1)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .SRC_D_OUT(SRC_D_OUT), .SRC_EMPTY_N(SRC_EMPTY_N),
    .SRC_DEQ(SRC_DEQ), .DST_D_IN(DST_D_IN), .DST_ENQ(DST_ENQ), .DST_FULL_N(DST_FULL_N),
    .DST_LAST(DST_LAST), .BUSY(BUSY)
  );

  fifo_unpack_reader #(.in_width(IN_W), .out_width(OUT_W), .lsb_first(1'b0)) dut_msb (
    .CLK(CLK), .RST(RST), .CLR(CLR), .SRC_D_OUT(SRC_D_OUT), .SRC_EMPTY_N(SRC_EMPTY_N),
    .SRC_DEQ(m_src_deq), .DST_D_IN(m_dst_d_in), .DST_ENQ(m_dst_enq), .DST_FULL_N(DST_FULL_N),
    .DST_LAST(m_dst_last), .BUSY(m_busy)
  );

  always #5 CLK = ~CLK;

  // Observed vector layout: [23] deq [22] enq [21] last [20] busy [19:12] data
  // for the LSB-first instance, same fields in [11:0] for the MSB-first one.
  function automatic logic [23:0] observe();
    return {SRC_DEQ, DST_ENQ, DST_LAST, BUSY, DST_D_IN,
            m_src_deq, m_dst_enq, m_dst_last, m_busy, m_dst_d_in};
  endfunction

  // One clock: drive inputs, predict outputs, sample at negedge, advance model.
  task automatic cycle(input bit clr, input bit full_n, input bit offer,
                       output logic [23:0] obs, output logic [23:0] exp,
                       output logic [23:0] mask);
    bit deq, enq, busy, last;
    logic [OUT_W-1:0] dl, dm;
    logic [IN_W-1:0] w;
    CLR         = clr;
    DST_FULL_N  = full_n;
    SRC_EMPTY_N = offer && (src_q.size() > 0);
    if (src_q.size() > 0) SRC_D_OUT = src_q[0];
    else                  SRC_D_OUT = $urandom;
    busy = (bq.size() > 0);
    enq  = busy && full_n && !clr;
    last = enq && (bq.size() == 1);
    deq  = SRC_EMPTY_N && !clr && (!busy || (bq.size() == 1 && full_n));
    dl = '0;
    dm = '0;
    if (busy) begin
      dl = bq[0].lsb;
      dm = bq[0].msb;
    end
    exp  = {deq, enq, last, busy, dl, deq, enq, last, busy, dm};
    mask = busy ? 24'hFFFFFF : DATA_MASK_OFF;
    @(negedge CLK);
    obs = observe();
    @(posedge CLK);
    if (clr) begin
      bq.delete();
    end else begin
      if (enq) void'(bq.pop_front());
      if (deq) begin
        w = src_q.pop_front();
        for (int k = 0; k < RATIO; k++)
          bq.push_back('{lsb: w[OUT_W*k +: OUT_W], msb: w[OUT_W*(RATIO-1-k) +: OUT_W]});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] obs, exp, mask;
    RST = 1'b1; CLR = 1'b0; DST_FULL_N = 1'b1; SRC_EMPTY_N = 1'b1; SRC_D_OUT = 32'hDEADBEEF;
    @(negedge CLK);
    obs = observe();
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 24'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    bq.delete();
    src_q.delete();
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1, 1'b1, obs, exp, mask);
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_single_word();
    logic [23:0] obs, exp, mask;
    logic [23:0] log_v[6];
    src_q.push_back(32'hA1B2C3D4);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b1, 1'b1, obs, exp, mask);
      log_v[c] = obs;
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL single_word cyc %0d: got %h expected %h", c, obs, exp);
      end
    end
    checks++;
    if ({log_v[0][23], log_v[1][19:12], log_v[4][19:12], log_v[1][7:0], log_v[4][7:0]} !==
        {1'b1, 8'hD4, 8'hA1, 8'hA1, 8'hD4}) begin
      errors++;
      $display("FAIL single_word_beats: got deq=%b b1=%h b4=%h m1=%h m4=%h expected deq=1 b1=d4 b4=a1 m1=a1 m4=d4",
               log_v[0][23], log_v[1][19:12], log_v[4][19:12], log_v[1][7:0], log_v[4][7:0]);
    end
    checks++;
    if ({log_v[3][21], log_v[4][21], log_v[4][20], log_v[5][20]} !== 4'b0110) begin
      errors++;
      $display("FAIL single_word_last_busy: got %b expected 0110",
               {log_v[3][21], log_v[4][21], log_v[4][20], log_v[5][20]});
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] obs, exp, mask;
    logic [23:0] log_v[10];
    src_q.push_back(32'h11223344);
    src_q.push_back(32'h55667788);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1, 1'b1, obs, exp, mask);
      log_v[c] = obs;
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", c, obs, exp);
      end
    end
    checks++;
    if ({log_v[4][23], log_v[4][19:12], log_v[5][19:12], log_v[5][22], log_v[8][21]} !==
        {1'b1, 8'h11, 8'h88, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL back_to_back_seam: got deq4=%b b4=%h b5=%h enq5=%b last8=%b expected 1 11 88 1 1",
               log_v[4][23], log_v[4][19:12], log_v[5][19:12], log_v[5][22], log_v[8][21]);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] obs, exp, mask;
    logic [23:0] log_v[8];
    src_q.push_back(32'hA1B2C3D4);
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, !(c == 2 || c == 3), 1'b1, obs, exp, mask);
      log_v[c] = obs;
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL backpressure cyc %0d: got %h expected %h", c, obs, exp);
      end
    end
    checks++;
    if ({log_v[2][22], log_v[3][22], log_v[3][19:12], log_v[4][22], log_v[4][19:12], log_v[6][21]} !==
        {1'b0, 1'b0, 8'hC3, 1'b1, 8'hC3, 1'b1}) begin
      errors++;
      $display("FAIL backpressure_hold: got enq2=%b enq3=%b d3=%h enq4=%b d4=%h last6=%b expected 0 0 c3 1 c3 1",
               log_v[2][22], log_v[3][22], log_v[3][19:12], log_v[4][22], log_v[4][19:12], log_v[6][21]);
    end
  endtask

  task automatic test_clear();
    logic [23:0] obs, exp, mask;
    logic [23:0] log_v[9];
    src_q.push_back(32'hA1B2C3D4);
    src_q.push_back(32'h55667788);
    for (int c = 0; c < 9; c++) begin
      cycle(c == 2, 1'b1, 1'b1, obs, exp, mask);
      log_v[c] = obs;
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL clear cyc %0d: got %h expected %h", c, obs, exp);
      end
    end
    checks++;
    if ({log_v[2][23:22], log_v[3][20], log_v[3][23], log_v[4][19:12]} !== {2'b00, 1'b0, 1'b1, 8'h88}) begin
      errors++;
      $display("FAIL clear_flush: got deqenq2=%b busy3=%b deq3=%b b4=%h expected 00 0 1 88",
               log_v[2][23:22], log_v[3][20], log_v[3][23], log_v[4][19:12]);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [23:0] obs, exp, mask;
    logic [23:0] log_v[6];
    src_q.push_back(32'hA1B2C3D4);
    src_q.push_back(32'hCAFEF00D);
    for (int c = 0; c < 2; c++) cycle(1'b0, 1'b1, 1'b1, obs, exp, mask);
    SRC_EMPTY_N = 1'b1;
    SRC_D_OUT   = src_q[0];
    #2;
    RST = 1'b1;
    #1;
    obs = observe();
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_word: got %h expected %h", obs, 24'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    bq.delete();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b1, 1'b1, obs, exp, mask);
      log_v[c] = obs;
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL reset_restart cyc %0d: got %h expected %h", c, obs, exp);
      end
    end
    checks++;
    if ({log_v[0][23], log_v[1][19:12], log_v[1][7:0]} !== {1'b1, 8'h0D, 8'hCA}) begin
      errors++;
      $display("FAIL reset_fresh_word: got deq0=%b b1=%h m1=%h expected 1 0d ca",
               log_v[0][23], log_v[1][19:12], log_v[1][7:0]);
    end
  endtask

  task automatic test_idle();
    logic [23:0] obs, exp, mask;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b1, 1'b0, obs, exp, mask);
      checks++;
      if ({obs[23:22], obs[11:10]} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_no_strobe cyc %0d: got %b expected 0000", c, {obs[23:22], obs[11:10]});
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] obs, exp, mask;
    for (int c = 0; c < 600; c++) begin
      if (src_q.size() == 0 && $urandom_range(0, 2) != 0) src_q.push_back($urandom);
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            obs, exp, mask);
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", c, obs, exp);
      end
    end
    src_q.delete();
    cycle(1'b1, 1'b1, 1'b0, obs, exp, mask);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_mid_word();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
